// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack op-codes, register-bank write selects and the
// stack sequencer state encoding.
package cpu_pkg;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    localparam logic [3:0] SEL_SP  = 4'd8;
    localparam logic [3:0] SEL_ISR = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_MEM     = 3'd2,
        ST_WB_DATA = 3'd3,
        ST_WB_SP   = 3'd4,
        ST_FAULT   = 3'd5
    } stack_state_t;

    // PUSH and CALL move SP down and write memory; POP and RET read and move SP up.
    function automatic logic is_push_type(input logic [1:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_engine.sv
// PUSH/POP/CALL/RET sequencer: one memory access per operation, results written
// back through the register bank's single write port while busy.
module stack_engine
    import cpu_pkg::*;
#(
    parameter logic [11:0] EMPTY_SP = 12'h000,
    parameter logic [11:0] LIMIT_SP = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [2:0]  op_reg,
    input  logic [15:0] push_data,
    input  logic [11:0] ret_pc,
    input  logic [11:0] sp_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_write_en,
    output logic [3:0]  rf_write_sel,
    output logic [15:0] rf_write_data,
    output logic        pc_load,
    output logic [11:0] pc_target,
    output logic        done,
    output logic        fault,
    output logic        busy
);

    stack_state_t state, state_nxt;

    logic [1:0]  op_q;
    logic [2:0]  reg_q;
    logic [15:0] data_q;
    logic [11:0] pc_q;
    logic [11:0] sp_q;
    logic [15:0] rdata_q;

    logic        push_type;
    logic [11:0] new_sp;

    assign push_type = is_push_type(op_q);
    // Full-descending: a push pre-decrements, so its address equals the new SP.
    assign new_sp    = push_type ? (sp_q - 12'd1) : (sp_q + 12'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_PUSH;
            reg_q   <= '0;
            data_q  <= '0;
            pc_q    <= '0;
            sp_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && op_valid) begin
                op_q   <= op_code;
                reg_q  <= op_reg;
                data_q <= push_data;
                pc_q   <= ret_pc;
                sp_q   <= sp_in;
            end
            if (state == ST_MEM && mem_ack) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (op_valid) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (push_type) state_nxt = (sp_q == LIMIT_SP) ? ST_FAULT : ST_MEM;
                else           state_nxt = (sp_q == EMPTY_SP) ? ST_FAULT : ST_MEM;
            end
            ST_MEM:     if (mem_ack) state_nxt = (op_q == OP_POP) ? ST_WB_DATA : ST_WB_SP;
            ST_WB_DATA: state_nxt = ST_WB_SP;
            ST_WB_SP:   state_nxt = ST_IDLE;
            ST_FAULT:   state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign op_ready = (state == ST_IDLE);
    assign busy     = !op_ready;

    // All buses are gated by state so they read zero whenever their state is inactive.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rf_write_en   = 1'b0;
        rf_write_sel  = '0;
        rf_write_data = '0;
        pc_load       = 1'b0;
        pc_target     = '0;
        done          = 1'b0;
        fault         = 1'b0;
        case (state)
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = push_type;
                mem_addr = push_type ? new_sp : sp_q;
                if (push_type) mem_wdata = (op_q == OP_CALL) ? {4'b0, pc_q} : data_q;
            end
            ST_WB_DATA: begin
                rf_write_en   = 1'b1;
                rf_write_sel  = {1'b0, reg_q};
                rf_write_data = rdata_q;
            end
            ST_WB_SP: begin
                rf_write_en   = 1'b1;
                rf_write_sel  = SEL_SP;
                rf_write_data = {4'b0, new_sp};
                done          = 1'b1;
                if (op_q == OP_RET) begin
                    pc_load   = 1'b1;
                    pc_target = rdata_q[11:0];
                end
            end
            ST_FAULT: begin
                done  = 1'b1;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
